// File: rtl/fr_adder_post_if.sv
// Handshake and data bundle between the fraction adder and its post-adder normalise stage.
// The master side drives the raw sum and consumes the packed single-precision result.
interface fr_adder_post_if #(
    parameter int FRAC_W = 24,
    parameter int EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [FRAC_W:0]   in_sum;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [FRAC_W-2:0] out_frac;
    logic              out_zero;
    logic              out_ovf;
    logic              out_unf;

    modport master (
        output in_valid, in_sign, in_exp, in_sum, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_frac, out_zero, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_sum, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_frac, out_zero, out_ovf, out_unf
    );
endinterface

// File: rtl/fr_adder_post.sv
// Post-adder normalise stage: shifts the magnitude sum one bit per cycle until the hidden bit
// is in place, then packs a truncated single-precision result with zero/overflow/denormal flags.
module fr_adder_post #(
    parameter int FRAC_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic                clock,
    input  logic                resetn,
    fr_adder_post_if.slave      bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Exponent carries one spare bit so the increment and overflow compare never wrap.
    localparam logic [EXP_W:0] E_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0] E_ONE = {{EXP_W{1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sign;
    logic [EXP_W:0]    r_e;
    logic [FRAC_W:0]   r_f;

    logic              r_out_valid;
    logic              r_out_sign;
    logic [EXP_W-1:0]  r_out_exp;
    logic [FRAC_W-2:0] r_out_frac;
    logic              r_out_zero;
    logic              r_out_ovf;
    logic              r_out_unf;

    logic              w_f_zero;
    logic              w_e_max;
    logic              w_carry;
    logic              w_norm;
    logic              w_e_low;
    logic              w_finish;
    logic [EXP_W:0]    w_e_inc;
    logic              w_accept;
    logic              w_load;

    logic              w_ld_sign;
    logic [EXP_W-1:0]  w_ld_exp;
    logic [FRAC_W-2:0] w_ld_frac;
    logic              w_ld_zero;
    logic              w_ld_ovf;
    logic              w_ld_unf;

    assign w_f_zero = (r_f == {(FRAC_W+1){1'b0}});
    assign w_e_max  = (r_e == E_MAX);
    assign w_carry  = r_f[FRAC_W];
    assign w_norm   = r_f[FRAC_W-1];
    assign w_e_low  = (r_e <= E_ONE);
    assign w_e_inc  = r_e + E_ONE;
    assign w_finish = w_f_zero | w_e_max | w_carry | w_norm | w_e_low;
    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_load   = (r_state == S_NORM) && w_finish;

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) w_state_nxt = S_NORM;
                else              w_state_nxt = S_IDLE;
            end
            S_NORM: begin
                if (w_finish) w_state_nxt = S_DONE;
                else          w_state_nxt = S_NORM;
            end
            S_DONE: begin
                if (bus.out_ready) w_state_nxt = S_IDLE;
                else               w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Result decode for the NORM->DONE load, in decision priority order.
    always_comb begin
        w_ld_sign = r_sign;
        w_ld_exp  = r_e[EXP_W-1:0];
        w_ld_frac = r_f[FRAC_W-2:0];
        w_ld_zero = 1'b0;
        w_ld_ovf  = 1'b0;
        w_ld_unf  = 1'b0;
        if (w_f_zero) begin
            w_ld_sign = 1'b0;
            w_ld_exp  = {EXP_W{1'b0}};
            w_ld_frac = {(FRAC_W-1){1'b0}};
            w_ld_zero = 1'b1;
        end else if (w_e_max) begin
            w_ld_exp  = {EXP_W{1'b1}};
            w_ld_frac = {(FRAC_W-1){1'b0}};
            w_ld_ovf  = 1'b1;
        end else if (w_carry) begin
            if (w_e_inc == E_MAX) begin
                w_ld_exp  = {EXP_W{1'b1}};
                w_ld_frac = {(FRAC_W-1){1'b0}};
                w_ld_ovf  = 1'b1;
            end else begin
                w_ld_exp  = w_e_inc[EXP_W-1:0];
                w_ld_frac = r_f[FRAC_W-1:1];
            end
        end else if (w_norm) begin
            w_ld_exp  = r_e[EXP_W-1:0];
        end else if (w_e_low) begin
            w_ld_exp  = {EXP_W{1'b0}};
            w_ld_unf  = 1'b1;
        end else begin
            w_ld_unf  = 1'b0;
        end
    end

    // Working registers: capture on accept, shift left while normalising.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sign <= 1'b0;
            r_e    <= {(EXP_W+1){1'b0}};
            r_f    <= {(FRAC_W+1){1'b0}};
        end else if (w_accept) begin
            r_sign <= bus.in_sign;
            r_e    <= (bus.in_exp == {EXP_W{1'b0}}) ? E_ONE : {1'b0, bus.in_exp};
            r_f    <= bus.in_sum;
        end else if ((r_state == S_NORM) && !w_finish) begin
            r_f    <= {r_f[FRAC_W-1:0], 1'b0};
            r_e    <= r_e - E_ONE;
        end else begin
            r_f    <= r_f;
            r_e    <= r_e;
        end
    end

    // Output registers: load once per result, hold until the next load.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_out_valid <= 1'b0;
            r_out_sign  <= 1'b0;
            r_out_exp   <= {EXP_W{1'b0}};
            r_out_frac  <= {(FRAC_W-1){1'b0}};
            r_out_zero  <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_unf   <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_sign  <= w_ld_sign;
            r_out_exp   <= w_ld_exp;
            r_out_frac  <= w_ld_frac;
            r_out_zero  <= w_ld_zero;
            r_out_ovf   <= w_ld_ovf;
            r_out_unf   <= w_ld_unf;
        end else if ((r_state == S_DONE) && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_sign  = r_out_sign;
    assign bus.out_exp   = r_out_exp;
    assign bus.out_frac  = r_out_frac;
    assign bus.out_zero  = r_out_zero;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.out_unf   = r_out_unf;
endmodule
